cordic_atan: RTL

CORDIC_ATAN -- requirements
Module: cordic_atan

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_atan_rom.sv | 11 +
 rtl/cordic_atan.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: default sizes, binary-angle quadrant offsets,
// the arctangent table and the FSM state encoding.
package cordic_pkg;

  localparam int CORDIC_ITER = 16;
  localparam int CORDIC_W    = 16;

  // Binary angle: 65536 counts per turn
  localparam logic [15:0] ANG_90  = 16'd16384;
  localparam logic [15:0] ANG_180 = 16'd32768;
  localparam logic [15:0] ANG_270 = 16'd49152;

  // atan(2^-i) in binary-angle counts
  localparam logic [15:0] ATAN_TAB [0:15] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup for micro-rotation index idx_i.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [15:0] atan_o
);

  always_comb atan_o = ATAN_TAB[idx_i];

endmodule

// File: rtl/cordic_atan.sv
// Iterative vectoring CORDIC: one micro-rotation per clock, producing
// atan2(Y,X) as a binary angle and the gain-scaled vector length.
module cordic_atan
  import cordic_pkg::*;
#(
  parameter int ITER = CORDIC_ITER,
  parameter int W    = CORDIC_W
) (
  input  logic           Clk_i,
  input  logic           Rst_i,
  input  logic [W-1:0]   X_i,
  input  logic [W-1:0]   Y_i,
  input  logic           Start_i,
  output logic [W-1:0]   Angle_o,
  output logic [W+1:0]   Magnitude_o,
  output logic           Busy_o,
  output logic           Done_o
);

  localparam int XW = W + 2;
  localparam int CW = $clog2(ITER + 1);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic [W-1:0]         z_q, z_d;
  logic [W-1:0]         angle_q, angle_d;
  logic [XW-1:0]        mag_q, mag_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 zero_q, zero_d;

  logic [3:0]           rom_idx;
  logic [15:0]          atan_val;
  logic signed [XW-1:0] xe, ye, xs, ys;

  assign rom_idx = 4'(cnt_q);

  cordic_atan_rom u_rom (
    .idx_i  (rom_idx),
    .atan_o (atan_val)
  );

  assign xe = {{2{X_i[W-1]}}, X_i};
  assign ye = {{2{Y_i[W-1]}}, Y_i};
  assign xs = x_q >>> cnt_q;
  assign ys = y_q >>> cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (Start_i) begin
          state_d = ST_ITER;
          busy_d  = 1'b1;
          cnt_d   = '0;
          zero_d  = (X_i == '0) && (Y_i == '0);
          // Fold left half-plane into |angle| <= 90 deg so the loop converges
          if (!xe[XW-1]) begin
            x_d = xe;
            y_d = ye;
            z_d = '0;
          end else if (!ye[XW-1]) begin
            x_d = ye;
            y_d = -xe;
            z_d = W'(ANG_90);
          end else begin
            x_d = -ye;
            y_d = xe;
            z_d = W'(ANG_270);
          end
        end
      end
      ST_ITER: begin
        if (cnt_q == CW'(ITER)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Zero vector would otherwise report the table sum as its angle
          angle_d = zero_q ? '0 : z_q;
          mag_d   = zero_q ? '0 : XW'(x_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!y_q[XW-1]) begin
            x_d = x_q + ys;
            y_d = y_q - xs;
            z_d = z_q + W'(atan_val);
          end else begin
            x_d = x_q - ys;
            y_d = y_q + xs;
            z_d = z_q - W'(atan_val);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      angle_q <= '0;
      mag_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign Angle_o     = angle_q;
  assign Magnitude_o = mag_q;
  assign Busy_o      = busy_q;
  assign Done_o      = done_q;

endmodule
